ctrl_seq: RTL and testbench

Parametrised multi-cycle sequencer for the rysyCore datapath. It replaces the fixed one-bit load phase and single next-NOP flag with an explicit state machine. The FSM drives a handshaked data-memory port with arbitrary wait states, inserts a configurable number of flush bubbles after control-flow redirects, and traps a hung memory access after a timeout. It sits beside the combinational decode (alu_op, imm_type, alu1/alu2/rd select, cmp_op, sel_type stay combinational). It owns every signal that depends on time: pc_sel, inst_sel, mem_sel, reg_wr and the memory strobes.

---
 rtl/ctrl_seq.sv | 176 +++++++++++++++++
 tb/tb_ctrl_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for the rysyCore datapath.
// Owns every time-dependent control: PC/instruction muxing, register write,
// the handshaked data-memory port, post-redirect flush bubbles and the
// memory-timeout trap. Outputs are Mealy (state, counters and inputs).
module ctrl_seq #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       b,
  input  logic       dmem_gnt,
  input  logic       dmem_rvalid,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic [1:0] pc_sel,
  output logic       mem_sel,
  output logic [1:0] inst_sel,
  output logic       reg_wr,
  output logic       stall,
  output logic       retire,
  output logic       fault
);

  // Opcode classes.
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;

  // Mux encodings (PC_M4 = 2'd3 exists but is never selected here).
  localparam logic [1:0] PcP4    = 2'd0;
  localparam logic [1:0] PcAlu   = 2'd1;
  localparam logic [1:0] PcOld   = 2'd2;
  localparam logic       MemPc   = 1'b0;
  localparam logic       MemAlu  = 1'b1;
  localparam logic [1:0] InstMem = 2'd0;
  localparam logic [1:0] InstOld = 2'd1;
  localparam logic [1:0] InstNop = 2'd2;

  localparam int unsigned TmoW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TmoW-1:0] TmoMax    = {TmoW{1'b1}};
  localparam logic [2:0]      FlushInit = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {StRun, StDreq, StDwait, StFlush, StFault} state_e;

  state_e          state_q, state_d;
  logic [2:0]      flush_q, flush_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            we_q, we_d;   // access is a store; keeps dmem_we stable until gnt

  logic [TmoW-1:0] tmo_inc;
  logic            tmo_hit;

  // Saturating access-age counter and the timeout condition for this cycle.
  always_comb begin
    tmo_inc = (tmo_q == TmoMax) ? tmo_q : tmo_q + 1'b1;
    tmo_hit = (TIMEOUT != 0) && (32'(tmo_inc) >= TIMEOUT);
  end

  // Next-state and Mealy output decode; rst forces the post-reset NOP.
  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    tmo_d    = tmo_q;
    we_d     = we_q;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_sel   = PcP4;
    mem_sel  = MemPc;
    inst_sel = InstNop;
    reg_wr   = 1'b0;
    stall    = 1'b0;
    retire   = 1'b0;
    fault    = 1'b0;

    if (rst) begin
      state_d = StFlush;
      flush_d = 3'd0;
      tmo_d   = '0;
      we_d    = 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          case (opcode)
            OpOp, OpOpImm, OpLui, OpAuipc: begin
              reg_wr   = 1'b1;
              inst_sel = InstMem;
              retire   = 1'b1;
            end
            OpBranch, OpJal, OpJalr: begin
              if (opcode != OpBranch || b) begin
                reg_wr   = (opcode != OpBranch);
                pc_sel   = PcAlu;
                inst_sel = InstNop;
                retire   = 1'b1;
                flush_d  = FlushInit;
                state_d  = StFlush;
              end else begin
                inst_sel = InstMem;
                retire   = 1'b1;
              end
            end
            OpLoad, OpStore: begin
              dmem_req = 1'b1;
              dmem_we  = (opcode == OpStore);
              mem_sel  = MemAlu;
              pc_sel   = PcOld;
              inst_sel = InstOld;
              we_d     = (opcode == OpStore);
              tmo_d    = '0;
              state_d  = dmem_gnt ? StDwait : StDreq;
            end
            default: begin
              inst_sel = InstMem;
              retire   = 1'b1;
            end
          endcase
        end
        StDreq: begin
          dmem_req = 1'b1;
          dmem_we  = we_q;
          mem_sel  = MemAlu;
          pc_sel   = PcOld;
          inst_sel = InstOld;
          stall    = 1'b1;
          tmo_d    = tmo_inc;
          if (tmo_hit)       state_d = StFault;
          else if (dmem_gnt) state_d = StDwait;
        end
        StDwait: begin
          mem_sel  = MemAlu;
          pc_sel   = PcOld;
          inst_sel = InstOld;
          stall    = 1'b1;
          tmo_d    = tmo_inc;
          // Completion beats a timeout that lands in the same cycle.
          if (dmem_rvalid) begin
            reg_wr   = ~we_q;
            mem_sel  = MemPc;
            pc_sel   = PcP4;
            inst_sel = InstNop;
            retire   = 1'b1;
            state_d  = StRun;
          end else if (tmo_hit) begin
            state_d = StFault;
          end
        end
        StFlush: begin
          if (flush_q == 3'd0) state_d = StRun;
          else                 flush_d = flush_q - 3'd1;
        end
        StFault: begin
          fault  = 1'b1;
          pc_sel = PcOld;
        end
        default: state_d = StFlush;
      endcase
    end
  end

  // State and counter registers; reset is folded into the next-state logic.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    flush_q <= flush_d;
    tmo_q   <= tmo_d;
    we_q    <= we_d;
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: two instances (FLUSH 3 / TIMEOUT 4 and FLUSH 1 / no
// timeout) checked every cycle against a transaction-level model, plus
// directed scenarios with hand-computed literal expectations.
module tb_ctrl_seq;

  localparam int N   = 2;
  localparam int FL0 = 3;
  localparam int TO0 = 4;
  localparam int FL1 = 1;
  localparam int TO1 = 0;

  localparam logic [6:0] ADD = 7'b0110011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    [N];
  logic [6:0] opcode [N];
  logic       b      [N];
  logic       gnt    [N];
  logic       rvalid [N];
  logic       req    [N];
  logic       we     [N];
  logic [1:0] pc_sel [N];
  logic       mem_sel[N];
  logic [1:0] inst_sel[N];
  logic       reg_wr [N];
  logic       stall  [N];
  logic       retire [N];
  logic       fault  [N];

  ctrl_seq #(.FLUSH_CYCLES(FL0), .TIMEOUT(TO0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .opcode(opcode[0]), .b(b[0]), .dmem_gnt(gnt[0]),
    .dmem_rvalid(rvalid[0]), .dmem_req(req[0]), .dmem_we(we[0]), .pc_sel(pc_sel[0]),
    .mem_sel(mem_sel[0]), .inst_sel(inst_sel[0]), .reg_wr(reg_wr[0]), .stall(stall[0]),
    .retire(retire[0]), .fault(fault[0])
  );

  ctrl_seq #(.FLUSH_CYCLES(FL1), .TIMEOUT(TO1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .opcode(opcode[1]), .b(b[1]), .dmem_gnt(gnt[1]),
    .dmem_rvalid(rvalid[1]), .dmem_req(req[1]), .dmem_we(we[1]), .pc_sel(pc_sel[1]),
    .mem_sel(mem_sel[1]), .inst_sel(inst_sel[1]), .reg_wr(reg_wr[1]), .stall(stall[1]),
    .retire(retire[1]), .fault(fault[1])
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int d, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", name, d, $time, act, exp);
    end
  endtask

  // Behavioural model: what the sequencer is doing, in transaction terms.
  bit m_valid[N];   // a reset has been seen
  bit m_fault[N];
  int m_flush[N];   // NOP cycles still owed
  bit m_acc  [N];   // memory access outstanding
  bit m_gnt  [N];   // request already accepted
  bit m_st   [N];
  int m_wait [N];   // cycles spent waiting on memory

  function automatic int flush_of(input int d);
    return (d == 0) ? FL0 : FL1;
  endfunction

  function automatic int tmo_of(input int d);
    return (d == 0) ? TO0 : TO1;
  endfunction

  task automatic model_check(input int d);
    int e_req, e_we, e_pc, e_mem, e_inst, e_wr, e_stall, e_ret, e_fault;
    bit active;
    e_req = 0; e_we = 0; e_pc = 0; e_mem = 0; e_inst = 2;
    e_wr = 0; e_stall = 0; e_ret = 0; e_fault = 0;
    active = 1'b1;
    if (rst[d]) begin
      m_valid[d] = 1'b1; m_fault[d] = 1'b0; m_flush[d] = 1; m_acc[d] = 1'b0;
    end else if (!m_valid[d]) begin
      active = 1'b0;
    end else if (m_fault[d]) begin
      e_fault = 1; e_pc = 2;
    end else if (m_flush[d] > 0) begin
      m_flush[d]--;
    end else if (m_acc[d]) begin
      e_stall = 1; e_mem = 1; e_pc = 2; e_inst = 1;
      m_wait[d]++;
      if (!m_gnt[d]) begin
        e_req = 1; e_we = int'(m_st[d]);
      end
      if (m_gnt[d] && rvalid[d]) begin
        e_mem = 0; e_pc = 0; e_inst = 2; e_ret = 1; e_wr = m_st[d] ? 0 : 1;
        m_acc[d] = 1'b0;
      end else if (tmo_of(d) != 0 && m_wait[d] >= tmo_of(d)) begin
        m_fault[d] = 1'b1; m_acc[d] = 1'b0;
      end else if (gnt[d]) begin
        m_gnt[d] = 1'b1;
      end
    end else begin
      case (opcode[d])
        7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
          e_wr = 1; e_inst = 0; e_ret = 1;
        end
        JAL, 7'b1100111, BR: begin
          if (opcode[d] == BR && !b[d]) begin
            e_inst = 0; e_ret = 1;
          end else begin
            e_pc = 1; e_inst = 2; e_ret = 1; e_wr = (opcode[d] == BR) ? 0 : 1;
            m_flush[d] = flush_of(d);
          end
        end
        LD, ST: begin
          e_req = 1; e_we = (opcode[d] == ST) ? 1 : 0; e_mem = 1; e_pc = 2; e_inst = 1;
          m_acc[d] = 1'b1; m_gnt[d] = gnt[d]; m_st[d] = (opcode[d] == ST); m_wait[d] = 0;
        end
        default: begin
          e_inst = 0; e_ret = 1;
        end
      endcase
    end
    if (active) begin
      chk("req", d, int'(req[d]), e_req);
      chk("we", d, int'(we[d]), e_we);
      chk("pc_sel", d, int'(pc_sel[d]), e_pc);
      chk("mem_sel", d, int'(mem_sel[d]), e_mem);
      chk("inst_sel", d, int'(inst_sel[d]), e_inst);
      chk("reg_wr", d, int'(reg_wr[d]), e_wr);
      chk("stall", d, int'(stall[d]), e_stall);
      chk("retire", d, int'(retire[d]), e_ret);
      chk("fault", d, int'(fault[d]), e_fault);
    end
  endtask

  // Compare process: outputs are settled mid-cycle, model advances per cycle.
  always @(negedge clk) begin
    for (int d = 0; d < N; d++) model_check(d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic r, input logic [6:0] op, input logic bb,
                         input logic g, input logic rv);
    for (int d = 0; d < N; d++) begin
      rst[d] = r; opcode[d] = op; b[d] = bb; gnt[d] = g; rvalid[d] = rv;
    end
  endtask

  logic [6:0] ops [11];
  int first [N];
  int rq1, st1, st0;

  initial begin
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h6f, 7'h67, 7'h03, 7'h23, 7'h00, 7'h73};
    for (int d = 0; d < N; d++) begin
      m_valid[d] = 1'b0; m_fault[d] = 1'b0; m_flush[d] = 0;
      m_acc[d] = 1'b0; m_gnt[d] = 1'b0; m_st[d] = 1'b0; m_wait[d] = 0;
    end
    set_all(1'b1, ADD, 1'b0, 1'b0, 1'b0);

    // Reset cycle, then exactly one NOP, then ADDs retire.
    @(negedge clk);
    chk("rst_req", 0, int'(req[0]), 0);
    chk("rst_inst", 0, int'(inst_sel[0]), 2);
    tick();
    set_all(1'b0, ADD, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_nop", 0, int'(inst_sel[0]), 2);
    chk("post_rst_ret", 1, int'(retire[1]), 0);
    tick();
    @(negedge clk);
    chk("add_ret", 0, int'(retire[0]), 1);
    chk("add_wr", 1, int'(reg_wr[1]), 1);
    chk("add_inst", 0, int'(inst_sel[0]), 0);
    tick();

    // JAL: redirect cycle then FLUSH_CYCLES bubbles.
    set_all(1'b0, JAL, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("jal_pc", 0, int'(pc_sel[0]), 1);
    chk("jal_wr", 0, int'(reg_wr[0]), 1);
    chk("jal_inst", 1, int'(inst_sel[1]), 2);
    tick();
    set_all(1'b0, ADD, 1'b0, 1'b0, 1'b0);
    first[0] = 0; first[1] = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int d = 0; d < N; d++) if (first[d] == 0 && inst_sel[d] == 2'd0) first[d] = c;
      tick();
    end
    chk("jal_gap", 0, first[0], 4);
    chk("jal_gap", 1, first[1], 2);

    // LOAD, gnt after 2 waits, rvalid after 3 waits; dut0 times out.
    rq1 = 0; st1 = 0; st0 = 0;
    for (int c = 0; c <= 7; c++) begin
      set_all(1'b0, (c <= 6) ? LD : ADD, 1'b0, (c == 2), (c == 6));
      @(negedge clk);
      if (c <= 6) begin
        rq1 += int'(req[1]); st1 += int'(stall[1]); st0 += int'(stall[0]);
      end
      if (c == 0) chk("ld_we", 1, int'(we[1]), 0);
      if (c == 4) chk("to_early", 0, int'(fault[0]), 0);
      if (c == 5) chk("to_fault", 0, int'(fault[0]), 1);
      if (c == 6) begin
        chk("ld_done_wr", 1, int'(reg_wr[1]), 1);
        chk("ld_done_ret", 1, int'(retire[1]), 1);
        chk("ld_done_pc", 1, int'(pc_sel[1]), 0);
      end
      if (c == 7) begin
        chk("fault_sticky", 0, int'(fault[0]), 1);
        chk("fault_req", 0, int'(req[0]), 0);
        chk("fault_ret", 0, int'(retire[0]), 0);
      end
      tick();
    end
    chk("ld_req_cycles", 1, rq1, 3);
    chk("ld_stall_cycles", 1, st1, 6);
    chk("to_stall_cycles", 0, st0, 4);

    // Reset clears the fault and gives one NOP.
    set_all(1'b1, ADD, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    set_all(1'b0, ADD, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_fault_clr", 0, int'(fault[0]), 0);
    chk("rst_fault_nop", 0, int'(inst_sel[0]), 2);
    tick();

    // STORE: rvalid together with gnt in DREQ is ignored.
    for (int c = 0; c <= 4; c++) begin
      set_all(1'b0, (c <= 3) ? ST : ADD, 1'b0, (c == 1), (c == 1 || c == 3));
      @(negedge clk);
      if (c == 0) begin
        chk("st_we", 0, int'(we[0]), 1);
        chk("st_req", 0, int'(req[0]), 1);
      end
      if (c == 1) chk("st_early_rv", 0, int'(retire[0]), 0);
      if (c == 2) chk("st_wait_req", 1, int'(req[1]), 0);
      if (c == 3) begin
        chk("st_done", 0, int'(retire[0]), 1);
        chk("st_no_wr", 1, int'(reg_wr[1]), 0);
      end
      tick();
    end

    // rvalid exactly in the 4th waiting cycle still completes on dut0.
    for (int c = 0; c <= 5; c++) begin
      set_all(1'b0, (c <= 4) ? LD : ADD, 1'b0, (c == 0), (c == 4));
      @(negedge clk);
      if (c == 4) chk("to_edge_done", 0, int'(retire[0]), 1);
      if (c == 5) chk("to_edge_nofault", 0, int'(fault[0]), 0);
      tick();
    end

    // Zero-wait LOAD completes in its second cycle.
    for (int c = 0; c <= 1; c++) begin
      set_all(1'b0, LD, 1'b0, (c == 0), (c == 1));
      @(negedge clk);
      if (c == 1) chk("ld0_done", 1, int'(retire[1]), 1);
      tick();
    end

    // Reset during DWAIT of a LOAD aborts it silently.
    for (int c = 0; c <= 3; c++) begin
      set_all((c == 1), (c == 0) ? LD : ADD, 1'b0, (c == 0), (c == 1));
      @(negedge clk);
      if (c == 1) begin
        chk("abort_ret", 0, int'(retire[0]), 0);
        chk("abort_wr", 0, int'(reg_wr[0]), 0);
      end
      if (c == 2) chk("abort_nop", 1, int'(inst_sel[1]), 2);
      if (c == 3) begin
        chk("abort_run", 1, int'(retire[1]), 1);
        chk("abort_noreq", 0, int'(req[0]), 0);
      end
      tick();
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < N; d++) begin
        rst[d] = ($urandom_range(0, 39) == 0);
        if (!m_acc[d]) opcode[d] = ops[$urandom_range(0, 10)];
        b[d]      = 1'($urandom_range(0, 1));
        gnt[d]    = 1'($urandom_range(0, 1));
        rvalid[d] = ($urandom_range(0, 9) < 5);
      end
      @(negedge clk);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
